pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, used between any two CPU pipeline stages (IF/ID first, then ID/EX, EX/MEM). It carries a PC and an instruction word plus a valid bit, and supports flushing to a bubble. In `SKID=1` mode it has a two-entry skid buffer, which gives registered `in_ready` and full throughput. Upstream stall and hazard logic drives `out_ready`/`in_valid` instead of ad-hoc hold inputs.

## Interface
- `PC_W`, default 32: PC field width.
- `INSTR_W`, default 32: instruction field width.
- `FLUSH_INSTR`, default 0 (`INSTR_W` bits): instruction value presented when no valid beat is held.
- `SKID`, default 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.

Ports (name, direction, width, meaning):
- `sys_clk` in 1: clock; all state updates on rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: synchronous flush; discards all held beats.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage can accept a beat.
- `in_pc` in `PC_W`: upstream PC.
- `in_instr` in `INSTR_W`: upstream instruction.
- `out_valid` out 1: beat presented downstream.
- `out_ready` in 1: downstream accepts.
- `out_pc` out `PC_W`: held PC.
- `out_instr` out `INSTR_W`: held instruction, or `FLUSH_INSTR` when `out_valid`=0.
- `occ` out 2: number of held beats (0..2; max 1 when `SKID=0`).

## Operation
- Handshake rules:
  - Input beat accepted when `in_valid & in_ready`.
  - Output beat consumed when `out_valid & out_ready`.
  - `out_pc`/`out_instr` stay stable while `out_valid & !out_ready`.
  - `in_pc`/`in_instr` are sampled only on accept.
- Priority: `sys_rst` > `flush_i` > handshake.
- Reset and flush both give `out_valid`=0, `occ`=0, skid empty, `out_instr`=`FLUSH_INSTR`.
  - Reset also sets `out_pc`=0.
  - Flush leaves `out_pc` unchanged.
  - A beat accepted in the flush cycle is dropped.
  - A beat consumed in the flush cycle counts as delivered.
- `SKID=1` state machine (state equals `occ`):
  - EMPTY: `in_ready`=1. Accept → main←in, go ONE.
  - ONE: `in_ready`=1.
    - Accept & consume → main←in, stay ONE.
    - Accept only → skid←in, go FULL.
    - Consume only → go EMPTY; main payload is held but `out_instr` shows `FLUSH_INSTR`.
  - FULL: `in_ready`=0. Consume → main←skid, go ONE.
- `SKID=1`: `in_ready` is a flop output equal to (state != FULL).
- `SKID=0`:
  - `in_ready` = `!out_valid | out_ready` (combinational).
  - Accept → main←in, `out_valid`←1.
  - Consume without accept → `out_valid`←0.
- `out_pc` keeps its last value when `out_valid`=0.
- The stage has no internal data transformation and no width conversion.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: 1 beat/cycle in both modes when `out_ready`=1.
- `SKID=1`: no combinational path from `out_ready` to `in_ready`. After `out_ready` deasserts, `in_ready` falls one cycle later, and the skid absorbs the one in-flight beat.
- `SKID=0`: a combinational path exists from `out_ready` to `in_ready`.
- Flush takes effect at the edge where `flush_i`=1: `out_valid`=0 in the following cycle. `in_ready`=1 in the following cycle.
- Reset mid-operation: same as flush, plus `out_pc`=0. The first accept is possible on the first edge with `sys_rst`=0.
- Order of beats is always preserved: FIFO depth 2, no reordering.

## Structure
- Shared package `pipe_pkg`:
  - State enum `occ_t` {EMPTY=0, ONE=1, FULL=2}.
  - Default `FLUSH_INSTR` constant `INSTR_NOP_ZERO`=0.
  - Payload struct `{pc, instr}` sized by `PC_W`/`INSTR_W`.
- One sub-module, `pipe_slot`: load-enabled payload register, instantiated once for main and once for skid (skid only when `SKID=1`, via generate).
- Control FSM lives in `pipe_stage_reg`.

## Test plan
- Reset: hold `sys_rst` 2 cycles with `in_valid`=1, `in_pc`=0x100 → `out_valid`=0, `out_pc`=0, `out_instr`=0, `occ`=0. After release, next edge accepts → `out_pc`=0x100.
- Streaming, `SKID=1`, `out_ready`=1: beats PC 0x0, 0x4, 0x8, 0xC on consecutive cycles → same sequence out, one cycle later, no gaps; `in_ready` stays 1.
- Backpressure: drop `out_ready` while streaming 0x10, 0x14, 0x18 → `out_pc` holds 0x10; `occ` goes 1→2; `in_ready`=0 the cycle after 0x14 is accepted; 0x18 waits. Raise `out_ready` → output 0x10, 0x14, 0x18 in order, no loss or duplication.
- Flush while FULL (0x20 main, 0x24 skid) with `in_valid`=1, `in_pc`=0x28 → next cycle `out_valid`=0, `out_instr`=`FLUSH_INSTR`, `occ`=0; 0x20, 0x24, 0x28 never appear.
- `SKID=0` build: `out_ready`=0 with `out_valid`=1 → `in_ready`=0 in the same cycle. `out_ready`=1 with `in_valid` → replace beat each cycle, throughput 1/cycle.
- `FLUSH_INSTR`=0x00000013: after reset and after any flush, `out_instr`=0x13 while `out_valid`=0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline-stage register family.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam int unsigned INSTR_NOP_ZERO = 0;

    localparam int DEFAULT_PC_W    = 32;
    localparam int DEFAULT_INSTR_W = 32;

    // Default-width payload; stages built with other widths declare their own matching struct.
    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]    pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } payload_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bus of a pipeline stage register.
interface pipe_stage_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// Load-enabled payload register used for the main and skid entries of a stage.
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying {pc, instr} with valid/ready handshake,
// flush-to-bubble and an optional two-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               PC_W        = 32,
    parameter int               INSTR_W     = 32,
    parameter logic [INSTR_W-1:0] FLUSH_INSTR = INSTR_W'(INSTR_NOP_ZERO),
    parameter bit               SKID        = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             flush_i,
    pipe_stage_reg_if.slave  bus,
    output logic [1:0]       occ
);

    localparam int W = PC_W + INSTR_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } slot_t;

    occ_t  state_q, state_d;
    slot_t main_q, skid_q, main_d, in_pl;
    logic  accept, consume, main_load, out_valid, in_ready;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign consume   = out_valid & bus.out_ready;
    assign in_pl     = {bus.in_pc, bus.in_instr};

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = ONE;
            ONE: begin
                if (accept && !consume) begin
                    state_d = FULL;
                end else if (!accept && consume) begin
                    state_d = EMPTY;
                end
            end
            FULL:    if (consume) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main refills from the skid when draining FULL, otherwise from the input.
    // Flush blocks the load so out_pc keeps the last presented value.
    assign main_d    = (state_q == FULL) ? skid_q : in_pl;
    assign main_load = !flush_i &&
                       ((state_q == FULL) ? consume
                                          : (accept && ((state_q == EMPTY) || consume)));

    pipe_slot #(.W(W)) u_main (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic in_ready_q;

            assign skid_load = !flush_i && accept && !consume && (state_q == ONE);

            pipe_slot #(.W(W)) u_skid (
                .clk_i  (sys_clk),
                .rst_i  (sys_rst),
                .load_i (skid_load),
                .d_i    (in_pl),
                .q_o    (skid_q)
            );

            // Registered ready: cuts the out_ready -> in_ready path.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != FULL);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_q   = '0;
            assign in_ready = !out_valid || bus.out_ready;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = main_q.pc;
    assign bus.out_instr = out_valid ? main_q.instr : FLUSH_INSTR;
    assign occ           = state_q;

endmodule
